rf_write_arbiter: RTL and testbench

//  Shares the single register-file write port among three requesters:
//  - WB writeback
//  - exception/interrupt save of the return PC into $k0
//  - UART receive bytes

---
 rtl/rf_write_arbiter.sv | 148 ++++++++++++++
 tb/tb_rf_write_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: WB writeback > exception $k0 save > queued UART bytes.
// Optional starvation guard enabled by defining RF_ARB_STARVE_GUARD_EN.
module rf_write_arbiter #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [4:0] EXC_ADDR   = 5'd26,
    parameter logic [4:0] UART_ADDR0 = 5'd24,
    parameter logic [4:0] UART_ADDR1 = 5'd25,
    parameter int         MAX_WAIT   = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wb_we,
    input  logic [4:0]                    wb_addr,
    input  logic [31:0]                   wb_data,
    input  logic                          exc_req,
    input  logic [31:0]                   exc_data,
    output logic                          exc_busy,
    input  logic                          uart_valid,
    input  logic                          uart_flag,
    input  logic [7:0]                    uart_data,
    output logic                          uart_ovf,
    input  logic                          ovf_clr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          stall_req,
    output logic                          rf_we,
    output logic [4:0]                    rf_addr,
    output logic [31:0]                   rf_wdata
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {EXC_IDLE, EXC_PEND} exc_state_t;

    exc_state_t      exc_state;
    logic [31:0]     exc_hold;
    logic [8:0]      fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;

    logic            wb_busy;
    logic            exc_grant;
    logic            fifo_empty;
    logic            fifo_full;
    logic            pop;
    logic            push;
    logic            drop;
    logic [8:0]      head;

    always_comb begin
        wb_busy    = wb_we && (wb_addr != 5'd0);
        fifo_empty = (fifo_count == '0);
        fifo_full  = (fifo_count == CW'(FIFO_DEPTH));
        head       = fifo_mem[rd_ptr];
        exc_grant  = !wb_busy && ((exc_state == EXC_PEND) || exc_req);
        pop        = !wb_busy && !exc_grant && !fifo_empty;
        // A full queue still accepts a byte when the head leaves in the same cycle.
        push       = uart_valid && (!fifo_full || pop);
        drop       = uart_valid && fifo_full && !pop;
    end

    always_comb begin
        rf_we    = 1'b0;
        rf_addr  = '0;
        rf_wdata = '0;
        if (rst_n) begin
            if (wb_busy) begin
                rf_we    = 1'b1;
                rf_addr  = wb_addr;
                rf_wdata = wb_data;
            end else if (exc_grant) begin
                rf_we    = 1'b1;
                rf_addr  = EXC_ADDR;
                rf_wdata = (exc_state == EXC_PEND) ? exc_hold : exc_data;
            end else if (pop) begin
                rf_we    = 1'b1;
                rf_addr  = head[8] ? UART_ADDR1 : UART_ADDR0;
                rf_wdata = {24'd0, head[7:0]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {uart_flag, uart_data};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exc_state  <= EXC_IDLE;
            exc_busy   <= 1'b0;
            exc_hold   <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            uart_ovf   <= 1'b0;
        end else begin
            case (exc_state)
                EXC_IDLE: if (exc_req && wb_busy) begin
                    exc_state <= EXC_PEND;
                    exc_busy  <= 1'b1;
                    exc_hold  <= exc_data;
                end
                EXC_PEND: if (!wb_busy) begin
                    exc_state <= EXC_IDLE;
                    exc_busy  <= 1'b0;
                end
                default: begin
                    exc_state <= EXC_IDLE;
                    exc_busy  <= 1'b0;
                end
            endcase

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase

            if (drop)         uart_ovf <= 1'b1;
            else if (ovf_clr) uart_ovf <= 1'b0;
        end
    end

`ifdef RF_ARB_STARVE_GUARD_EN
    localparam int WW = $clog2(MAX_WAIT + 1);
    logic [WW-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt  <= '0;
            stall_req <= 1'b0;
        end else if (fifo_empty || pop) begin
            wait_cnt  <= '0;
            stall_req <= 1'b0;
        end else begin
            if (wait_cnt != WW'(MAX_WAIT)) wait_cnt <= wait_cnt + 1'b1;
            // Rises on the same edge the counter reaches MAX_WAIT.
            if (wait_cnt >= WW'(MAX_WAIT - 1)) stall_req <= 1'b1;
        end
    end
`else
    assign stall_req = 1'b0;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter (default parameters).
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        exc_req;
    logic [31:0] exc_data;
    logic        exc_busy;
    logic        uart_valid;
    logic        uart_flag;
    logic [7:0]  uart_data;
    logic        uart_ovf;
    logic        ovf_clr;
    logic [2:0]  fifo_count;
    logic        stall_req;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wdata;

    int unsigned total = 0;
    int unsigned bad   = 0;

    rf_write_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .exc_req    (exc_req),
        .exc_data   (exc_data),
        .exc_busy   (exc_busy),
        .uart_valid (uart_valid),
        .uart_flag  (uart_flag),
        .uart_data  (uart_data),
        .uart_ovf   (uart_ovf),
        .ovf_clr    (ovf_clr),
        .fifo_count (fifo_count),
        .stall_req  (stall_req),
        .rf_we      (rf_we),
        .rf_addr    (rf_addr),
        .rf_wdata   (rf_wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_write(input string tag, input logic [4:0] a, input logic [31:0] d);
        #1;
        check({tag, "_we"}, {31'd0, rf_we}, 32'd1);
        check({tag, "_addr"}, {27'd0, rf_addr}, {27'd0, a});
        check({tag, "_data"}, rf_wdata, d);
    endtask

    initial begin
        logic [7:0] b;
        rst_n = 1'b0; ovf_clr = 1'b0;
        wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h5555_5555;
        exc_req = 1'b1; exc_data = 32'h1111_1111;
        uart_valid = 1'b1; uart_flag = 1'b1; uart_data = 8'h77;
        tick(); tick();
        check("rst_rf_we", {31'd0, rf_we}, 32'd0);
        check("rst_rf_addr", {27'd0, rf_addr}, 32'd0);
        check("rst_rf_wdata", rf_wdata, 32'd0);
        check("rst_count", {29'd0, fifo_count}, 32'd0);
        check("rst_exc_busy", {31'd0, exc_busy}, 32'd0);
        check("rst_stall", {31'd0, stall_req}, 32'd0);
        wb_we = 1'b0; exc_req = 1'b0; uart_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        check("post_rst_ovf", {31'd0, uart_ovf}, 32'd0);
        check("post_rst_count", {29'd0, fifo_count}, 32'd0);
        check("idle_rf_we", {31'd0, rf_we}, 32'd0);

        // Exception collides with WB
        wb_we = 1'b1; wb_addr = 5'd8; wb_data = 32'h0000_1234;
        exc_req = 1'b1; exc_data = 32'h0040_0104;
        check_write("coll_wb", 5'd8, 32'h0000_1234);
        tick();
        exc_req = 1'b1; exc_data = 32'hDEAD_BEEF;
        check_write("coll_wb2", 5'd8, 32'h0000_1234);
        check("coll_busy", {31'd0, exc_busy}, 32'd1);
        tick();
        exc_req = 1'b0; wb_we = 1'b0;
        check_write("coll_exc", 5'd26, 32'h0040_0104);
        tick();
        check("coll_busy_drop", {31'd0, exc_busy}, 32'd0);
        check("coll_no_repeat", {31'd0, rf_we}, 32'd0);

        // Exception with port free is written immediately
        exc_req = 1'b1; exc_data = 32'h8000_0180;
        check_write("exc_direct", 5'd26, 32'h8000_0180);
        tick();
        exc_req = 1'b0;
        check("exc_direct_busy", {31'd0, exc_busy}, 32'd0);

        // No bypass, then WB to $0 leaves the port to the UART head
        uart_valid = 1'b1; uart_flag = 1'b0; uart_data = 8'h5A;
        #1 check("no_bypass", {31'd0, rf_we}, 32'd0);
        tick();
        uart_valid = 1'b0;
        check("one_queued", {29'd0, fifo_count}, 32'd1);
        wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
        check_write("wb_zero", 5'd24, 32'h0000_005A);
        tick();
        wb_we = 1'b0;
        check("wb_zero_pop", {29'd0, fifo_count}, 32'd0);

        // Overflow while WB holds the port
        wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h33;
        for (int i = 0; i < 5; i++) begin
            uart_valid = 1'b1; uart_flag = i[0]; uart_data = 8'hA0 + 8'(i);
            tick();
        end
        uart_valid = 1'b0;
        check("ovf_count", {29'd0, fifo_count}, 32'd4);
        check("ovf_set", {31'd0, uart_ovf}, 32'd1);
        wb_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b = 8'hA0 + 8'(i);
            check_write("drain", (i % 2 == 1) ? 5'd25 : 5'd24, {24'd0, b});
            tick();
        end
        check("drain_empty", {29'd0, fifo_count}, 32'd0);
        check("ovf_sticky", {31'd0, uart_ovf}, 32'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_clr", {31'd0, uart_ovf}, 32'd0);

        // Overflow beats a simultaneous clear, then full plus pop
        wb_we = 1'b1; wb_addr = 5'd3;
        for (int i = 0; i < 4; i++) begin
            uart_valid = 1'b1; uart_flag = i[0]; uart_data = 8'hB0 + 8'(i);
            tick();
        end
        uart_data = 8'hBF; ovf_clr = 1'b1;
        tick();
        uart_valid = 1'b0;
        check("ovf_vs_clr", {31'd0, uart_ovf}, 32'd1);
        tick();
        ovf_clr = 1'b0;
        check("ovf_clr2", {31'd0, uart_ovf}, 32'd0);
        wb_we = 1'b0;
        uart_valid = 1'b1; uart_flag = 1'b1; uart_data = 8'hC4;
        check_write("full_pop", 5'd24, 32'h0000_00B0);
        tick();
        uart_valid = 1'b0;
        check("full_pop_count", {29'd0, fifo_count}, 32'd4);
        check("full_pop_ovf", {31'd0, uart_ovf}, 32'd0);
        check_write("fp_b1", 5'd25, 32'h0000_00B1); tick();
        check_write("fp_b2", 5'd24, 32'h0000_00B2); tick();
        check_write("fp_b3", 5'd25, 32'h0000_00B3); tick();
        check_write("fp_c4", 5'd25, 32'h0000_00C4); tick();
        check("fp_empty", {29'd0, fifo_count}, 32'd0);

        // Exception outranks a queued UART byte
        uart_valid = 1'b1; uart_flag = 1'b0; uart_data = 8'hD1;
        tick();
        uart_valid = 1'b0; exc_req = 1'b1; exc_data = 32'h0000_0011;
        check_write("exc_over_uart", 5'd26, 32'h0000_0011);
        tick();
        exc_req = 1'b0;
        check("exc_over_uart_cnt", {29'd0, fifo_count}, 32'd1);
        check_write("uart_after_exc", 5'd24, 32'h0000_00D1);
        tick();

        // Starvation: one entry, WB busy for 20 cycles
        uart_valid = 1'b1; uart_flag = 1'b0; uart_data = 8'hE5;
        tick();
        uart_valid = 1'b0; wb_we = 1'b1; wb_addr = 5'd7;
        for (int c = 0; c < 20; c++) begin
            #1;
`ifdef RF_ARB_STARVE_GUARD_EN
            check("starve_stall", {31'd0, stall_req}, (c >= 8) ? 32'd1 : 32'd0);
`else
            check("starve_stall", {31'd0, stall_req}, 32'd0);
`endif
            tick();
        end
        wb_we = 1'b0;
        check_write("starve_write", 5'd24, 32'h0000_00E5);
        tick();
        check("starve_release", {31'd0, stall_req}, 32'd0);
        check("starve_empty", {29'd0, fifo_count}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
